mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32 pipeline, between execute and writeback. It accepts one instruction per handshake from execute, performs loads and stores over a single-outstanding data-memory bus, and stalls execute while an access is in flight. It presents registered results to writeback: destination register, raw aligned load data or ALU result, and funct3, which writeback uses for sign/zero extension. A watchdog counter converts an unresponsive bus into an error.

## Interface
- TIMEOUT_CYC, 255: maximum cycles `dm_req` waits for `dm_ready` before the access is aborted (1..65535).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute presents an instruction.
- ex_rd  in  5  destination register.
- ex_alu_out  in  32  ALU result; this is the effective address for memory ops.
- ex_store_data  in  32  rs2 value for stores.
- ex_f3  in  3  funct3.
- ex_mem_r / ex_mem_w / ex_reg_w  in  1 each  load / store / ALU writeback; mutually exclusive.
- stall  out  1  execute must hold its outputs; `ex_valid` is accepted only when `stall`=0.
- dm_req  out  1  bus request, held until `dm_ready`.
- dm_we  out  1  1=write.
- dm_addr  out  32  word address ({addr[31:2],2'b00}).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_ready  in  1  bus completes the access this cycle.
- dm_rdata  in  32  read data, valid with `dm_ready`.
- alu_rd  out  5  destination register to writeback.
- d_out  out  32  ALU result, or load word shifted right by 8*addr[1:0].
- f3_out  out  3  funct3 to writeback.
- d_r_en / d_w_en / alu_reg_w_en  out  1 each  retired load / store / ALU op; each a one-cycle pulse.
- err  out  1  one-cycle pulse with a retired op that faulted (timeout, illegal funct3, misalign).

## Operation
- FSM states are IDLE, BUS and DONE.
- IDLE: `stall`=0. On `ex_valid`:
  - ALU op or no-op: retire next edge.
  - Memory op: latch address/f3/rd/data, compute `dm_be`/`dm_wdata`, go to BUS.
- BUS: `dm_req`=1, `stall`=1, watchdog counting.
  - On `dm_ready`: capture and align `dm_rdata`, go to DONE.
  - On count reaching TIMEOUT_CYC: drop `dm_req`, go to DONE with the fault flag set.
- DONE: pulse the retire enables (and `err` if faulted); `d_r_en`/`d_w_en` are forced 0 on a fault. `stall`=1 this cycle; return to IDLE.
- Byte enables by offset o=addr[1:0]:
  - Byte: 4'b0001<<o, data {4{sd[7:0]}}.
  - Half: 4'b0011<<o, data {2{sd[15:0]}}.
  - Word: 4'b1111, data sd.
- A memory op with funct3 011, 110, 111 (load) or any funct3 other than 000/001/010 (store) faults immediately: no bus access, retires via DONE with `err`.
- `alu_rd`, `d_out` and `f3_out` hold their last value until the next retire. The enables and `err` are 0 when not retiring.
- Reset (asynchronous, any state, including mid-BUS) forces state IDLE and all outputs to 0, and clears the watchdog. A dropped request is not reissued.

## Timing
- ALU op: accepted at edge E0, outputs valid after E0 for one cycle; throughput 1/cycle.
- Memory op: accepted at E0 → `dm_req` high after E0. With `dm_ready` sampled at edge E(k), retire outputs are valid after E(k+1). The minimum is 3 cycles accept-to-retire for a zero-wait bus.
- Back-to-back ALU ops while a memory op is in BUS/DONE are held by `stall`. No op is lost or duplicated.
- Watchdog: fault is taken at the TIMEOUT_CYC-th BUS cycle without `dm_ready`. A `dm_ready` arriving in the same cycle wins (normal completion).
- `dm_addr`, `dm_be`, `dm_wdata` and `dm_we` are stable for the whole BUS phase.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]≠0 faults at accept (no bus access; retires with `err`=1, enables 0).
- Undefined: misaligned low address bits are ignored. The access is forced to natural alignment (half uses addr[1], word uses offset 0), and `err` is never raised for alignment.

## Test plan
- Reset mid-BUS: assert `rst`=0 with `dm_req`=1 → `dm_req`, `stall` and all outputs are 0 immediately. After release, accept a new ALU op normally.
- SB at addr 0x1003, data 0x000000A5, zero-wait bus → `dm_be`=1000, `dm_wdata`=0xA5A5A5A5, `d_w_en` pulses 3 cycles after accept.
- LH at 0x2002, `dm_rdata`=0x8001_1234 after 2 wait states → `d_out`=0x00008001, `f3_out`=001, `d_r_en` pulse, `alu_reg_w_en`=0.
- ALU stream of 4 ops (rd 1..4) → 4 consecutive `alu_reg_w_en` pulses with `d_out` equal to each `ex_alu_out`, and `stall` never high.
- Bus never ready, TIMEOUT_CYC=8 → `dm_req` drops after 8 cycles, `err`=1 with `d_r_en`=0. A follow-on ALU op is accepted the next idle cycle.
- LW at 0x3001: with MEM_MISALIGN_TRAP_EN → `err`=1, no `dm_req`. Without it → `dm_addr`=0x3000, `d_r_en`=1, `err`=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage. It has a single-outstanding data bus with a
// watchdog, and its results to writeback are registered.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_f3,
  input  logic        ex_mem_r,
  input  logic        ex_mem_w,
  input  logic        ex_reg_w,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic [4:0]  alu_rd,
  output logic [31:0] d_out,
  output logic [2:0]  f3_out,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic        alu_reg_w_en,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] wd_cnt;
  logic        timeout;
  logic [31:0] addr_q;
  logic [31:0] ld_data;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        rd_op_q, wr_op_q, fault_q;

  logic        mem_op, f3_bad, misalign, bad;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign mem_op = ex_mem_r | ex_mem_w;
  // Stores allow only SB/SH/SW; loads reject 011, 110 and 111.
  assign f3_bad = ex_mem_w ? (ex_f3[2] | (ex_f3[1:0] == 2'b11))
                           : ((ex_f3[1:0] == 2'b11) | (ex_f3 == 3'b110));
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((ex_f3[1:0] == 2'b01) && ex_alu_out[0]) ||
                    ((ex_f3[1:0] == 2'b10) && (ex_alu_out[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign bad = f3_bad | misalign;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    off   = 2'b00;
    be    = 4'b1111;
    wdata = ex_store_data;
    case (ex_f3[1:0])
      2'b00: begin
        off   = ex_alu_out[1:0];
        be    = 4'b0001 << off;
        wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        off   = {ex_alu_out[1], 1'b0};
        be    = 4'b0011 << off;
        wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign stall  = (state != IDLE);
  assign dm_req = (state == BUS);

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE: if (ex_valid && mem_op) state_nxt = bad ? DONE : BUS;
      BUS: begin
        if (dm_ready) begin
          state_nxt = DONE;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt       <= '0;
      addr_q       <= '0;
      ld_data      <= '0;
      rd_q         <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rd_op_q      <= 1'b0;
      wr_op_q      <= 1'b0;
      fault_q      <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_be        <= '0;
      dm_wdata     <= '0;
      alu_rd       <= '0;
      d_out        <= '0;
      f3_out       <= '0;
      d_r_en       <= 1'b0;
      d_w_en       <= 1'b0;
      alu_reg_w_en <= 1'b0;
      err          <= 1'b0;
    end else begin
      d_r_en       <= 1'b0;
      d_w_en       <= 1'b0;
      alu_reg_w_en <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && mem_op) begin
            addr_q   <= ex_alu_out;
            rd_q     <= ex_rd;
            f3_q     <= ex_f3;
            off_q    <= off;
            rd_op_q  <= ex_mem_r;
            wr_op_q  <= ex_mem_w;
            fault_q  <= bad;
            ld_data  <= '0;
            wd_cnt   <= '0;
            dm_we    <= ex_mem_w & ~bad;
            dm_addr  <= {ex_alu_out[31:2], 2'b00};
            dm_be    <= bad ? 4'b0000 : be;
            dm_wdata <= wdata;
          end else if (ex_valid) begin
            alu_rd       <= ex_rd;
            d_out        <= ex_alu_out;
            f3_out       <= ex_f3;
            alu_reg_w_en <= ex_reg_w;
          end
        end
        BUS: begin
          if (dm_ready)     ld_data <= dm_rdata >> {off_q, 3'b000};
          else if (timeout) fault_q <= 1'b1;
          else              wd_cnt  <= wd_cnt + 16'd1;
        end
        DONE: begin
          alu_rd <= rd_q;
          f3_out <= f3_q;
          d_out  <= rd_op_q ? ld_data : addr_q;
          d_r_en <= rd_op_q & ~fault_q;
          d_w_en <= wr_op_q & ~fault_q;
          err    <= fault_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table for mem_stage (TIMEOUT_CYC=8) plus hand sequences for
// ALU streaming, stall holding and reset during a bus access.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_alu_out = '0;
  logic [31:0] ex_store_data = '0;
  logic [2:0]  ex_f3 = '0;
  logic        ex_mem_r = 1'b0, ex_mem_w = 1'b0, ex_reg_w = 1'b0;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, d_out;
  logic [3:0]  dm_be;
  logic        dm_ready = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic [4:0]  alu_rd;
  logic [2:0]  f3_out;
  logic        d_r_en, d_w_en, alu_reg_w_en, err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_f3(ex_f3), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_reg_w(ex_reg_w), .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .alu_rd(alu_rd), .d_out(d_out), .f3_out(f3_out), .d_r_en(d_r_en), .d_w_en(d_w_en),
    .alu_reg_w_en(alu_reg_w_en), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b010;
  localparam logic [2:0] OP_ALU = 3'b001;
  localparam logic [3:0] EN_ALU = 4'b1000;
  localparam logic [3:0] EN_R   = 4'b0100;
  localparam logic [3:0] EN_W   = 4'b0010;
  localparam logic [3:0] EN_ERR = 4'b0001;
  localparam int         NEVER  = 255;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [2:0]  op;
    int          waits;
    logic [31:0] rdata;
    int          lat;
    int          reqs;
    logic [3:0]  en;
    logic        chk_dout;
    logic [31:0] dout;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
  } vec_t;

  function automatic vec_t mk(logic [4:0] rd, logic [2:0] f3, logic [31:0] addr, logic [31:0] sd,
                              logic [2:0] op, int waits, logic [31:0] rdata, int lat, int reqs,
                              logic [3:0] en, logic chk_dout, logic [31:0] dout,
                              logic [31:0] exp_addr, logic [3:0] exp_be, logic [31:0] exp_wdata,
                              logic exp_we);
    vec_t v;
    v.rd = rd; v.f3 = f3; v.addr = addr; v.sd = sd; v.op = op; v.waits = waits;
    v.rdata = rdata; v.lat = lat; v.reqs = reqs; v.en = en; v.chk_dout = chk_dout;
    v.dout = dout; v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_we = exp_we;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_mem_r = 1'b0; ex_mem_w = 1'b0; ex_reg_w = 1'b0;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [2:0] op);
    ex_valid = 1'b1; ex_rd = rd; ex_f3 = f3; ex_alu_out = addr; ex_store_data = sd;
    ex_mem_r = op[2]; ex_mem_w = op[1]; ex_reg_w = op[0];
  endtask

  // Issue one op from IDLE, serve the bus, then compare the retire cycle against the record.
  task automatic run_vec(input string tag, input vec_t v);
    int          lat, reqs;
    logic        done, stable, we0;
    logic [31:0] a0, w0;
    logic [3:0]  b0, en_seen;
    logic [31:0] dout_seen;
    logic [4:0]  rd_seen;
    logic [2:0]  f3_seen;
    logic        stall_seen;
    lat = 0; reqs = 0; done = 1'b0; stable = 1'b1;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0; en_seen = '0;
    dout_seen = '0; rd_seen = '0; f3_seen = '0; stall_seen = 1'b0;
    @(negedge clk);
    drive_ex(v.rd, v.f3, v.addr, v.sd, v.op);
    @(posedge clk); #1;
    clear_ex();
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dm_req) begin
        if (reqs == 0) begin
          a0 = dm_addr; b0 = dm_be; w0 = dm_wdata; we0 = dm_we;
        end else if (dm_addr !== a0 || dm_be !== b0 || dm_wdata !== w0 || dm_we !== we0) begin
          stable = 1'b0;
        end
        dm_ready = (reqs == v.waits);
        dm_rdata = (reqs == v.waits) ? v.rdata : 32'h0BAD_F00D;
        reqs++;
      end else begin
        dm_ready = 1'b0;
      end
      if (alu_reg_w_en || d_r_en || d_w_en || err) begin
        done = 1'b1;
        en_seen = {alu_reg_w_en, d_r_en, d_w_en, err};
        dout_seen = d_out; rd_seen = alu_rd; f3_seen = f3_out; stall_seen = stall;
      end
    end
    dm_ready = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_enables"}, {28'd0, en_seen}, {28'd0, v.en});
    check({tag, "_req_cycles"}, 32'(reqs), 32'(v.reqs));
    check({tag, "_stall_at_retire"}, {31'd0, stall_seen}, 32'd0);
    if (v.chk_dout) begin
      check({tag, "_d_out"}, dout_seen, v.dout);
      check({tag, "_alu_rd"}, {27'd0, rd_seen}, {27'd0, v.rd});
      check({tag, "_f3_out"}, {29'd0, f3_seen}, {29'd0, v.f3});
    end
    if (v.reqs > 0) begin
      check({tag, "_dm_addr"}, a0, v.exp_addr);
      check({tag, "_dm_be"}, {28'd0, b0}, {28'd0, v.exp_be});
      check({tag, "_dm_we"}, {31'd0, we0}, {31'd0, v.exp_we});
      if (v.op == OP_ST) check({tag, "_dm_wdata"}, w0, v.exp_wdata);
      check({tag, "_bus_stable"}, {31'd0, stable}, 32'd1);
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, {28'd0, alu_reg_w_en, d_r_en, d_w_en, err}, 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int   n_alu, n_w, guard;
    logic order_ok, dropped;

    vecs[0]  = mk(5'd0, 3'b000, 32'h0000_1003, 32'h0000_00A5, OP_ST, 0, 32'h0, 3, 1, EN_W,
                  1'b0, 32'h0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b1);
    vecs[1]  = mk(5'd5, 3'b001, 32'h0000_2002, 32'h0, OP_LD, 2, 32'h8001_1234, 5, 3, EN_R,
                  1'b1, 32'h0000_8001, 32'h0000_2000, 4'b1100, 32'h0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[2]  = mk(5'd6, 3'b010, 32'h0000_3001, 32'h0, OP_LD, 0, 32'hDEAD_BEEF, 2, 0, EN_ERR,
                  1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    vecs[10] = mk(5'd0, 3'b001, 32'h0000_5003, 32'h0000_1234, OP_ST, 0, 32'h0, 2, 0, EN_ERR,
                  1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
`else
    vecs[2]  = mk(5'd6, 3'b010, 32'h0000_3001, 32'h0, OP_LD, 0, 32'hDEAD_BEEF, 3, 1, EN_R,
                  1'b1, 32'hDEAD_BEEF, 32'h0000_3000, 4'b1111, 32'h0, 1'b0);
    vecs[10] = mk(5'd0, 3'b001, 32'h0000_5003, 32'h0000_1234, OP_ST, 0, 32'h0, 3, 1, EN_W,
                  1'b0, 32'h0, 32'h0000_5000, 4'b1100, 32'h1234_1234, 1'b1);
`endif
    vecs[3]  = mk(5'd7, 3'b100, 32'h0000_4001, 32'h0, OP_LD, 1, 32'h1122_3344, 4, 2, EN_R,
                  1'b1, 32'h0011_2233, 32'h0000_4000, 4'b0010, 32'h0, 1'b0);
    vecs[4]  = mk(5'd0, 3'b001, 32'h0000_5002, 32'h0000_BEEF, OP_ST, 0, 32'h0, 3, 1, EN_W,
                  1'b0, 32'h0, 32'h0000_5000, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    vecs[5]  = mk(5'd0, 3'b010, 32'h0000_6000, 32'h1234_5678, OP_ST, 3, 32'h0, 6, 4, EN_W,
                  1'b0, 32'h0, 32'h0000_6000, 4'b1111, 32'h1234_5678, 1'b1);
    vecs[6]  = mk(5'd0, 3'b011, 32'h0000_6000, 32'h1, OP_ST, 0, 32'h0, 2, 0, EN_ERR,
                  1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    vecs[7]  = mk(5'd8, 3'b110, 32'h0000_6000, 32'h0, OP_LD, 0, 32'h0, 2, 0, EN_ERR,
                  1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    vecs[8]  = mk(5'd10, 3'b000, 32'h0000_7000, 32'h0, OP_LD, NEVER, 32'h0, 10, 8, EN_ERR,
                  1'b0, 32'h0, 32'h0000_7000, 4'b0001, 32'h0, 1'b0);
    vecs[9]  = mk(5'd11, 3'b101, 32'h0000_7002, 32'h0, OP_LD, 7, 32'hCAFE_1234, 10, 8, EN_R,
                  1'b1, 32'h0000_CAFE, 32'h0000_7000, 4'b1100, 32'h0, 1'b0);
    vecs[11] = mk(5'd9, 3'b101, 32'hCAFE_F00D, 32'h0, OP_ALU, 0, 32'h0, 1, 0, EN_ALU,
                  1'b1, 32'hCAFE_F00D, 32'h0, 4'b0000, 32'h0, 1'b0);
    vecs[12] = mk(5'd0, 3'b000, 32'h0000_8001, 32'h0000_007E, OP_ST, 1, 32'h0, 4, 2, EN_W,
                  1'b0, 32'h0, 32'h0000_8000, 4'b0010, 32'h7E7E_7E7E, 1'b1);

    repeat (2) @(negedge clk);
    check("reset_stall_req", {30'd0, stall, dm_req}, 32'd0);
    check("reset_enables", {28'd0, alu_reg_w_en, d_r_en, d_w_en, err}, 32'd0);
    check("reset_d_out", d_out, 32'd0);
    check("reset_bus", {dm_be, 27'd0, dm_we}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Four back-to-back ALU ops retire on consecutive cycles without stalling.
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      drive_ex(5'(i), 3'b000, 32'h1111_0000 + 32'(i), 32'h0, OP_ALU);
      check($sformatf("stream%0d_stall", i), {31'd0, stall}, 32'd0);
      @(negedge clk);
      check($sformatf("stream%0d_en", i), {31'd0, alu_reg_w_en}, 32'd1);
      check($sformatf("stream%0d_d_out", i), d_out, 32'h1111_0000 + 32'(i));
      check($sformatf("stream%0d_rd", i), {27'd0, alu_rd}, 32'(i));
    end
    clear_ex();
    @(negedge clk);
    check("stream_end_en", {31'd0, alu_reg_w_en}, 32'd0);

    // An ALU op presented during a store is held by stall and retires exactly once, afterwards.
    dm_ready = 1'b1;
    drive_ex(5'd0, 3'b010, 32'h0000_A000, 32'h5555_AAAA, OP_ST);
    @(posedge clk); #1;
    drive_ex(5'd12, 3'b000, 32'h0000_0ABC, 32'h0, OP_ALU);
    n_alu = 0; n_w = 0; order_ok = 1'b1; dropped = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (alu_reg_w_en) begin
        n_alu++;
        if (n_w == 0) order_ok = 1'b0;
      end
      if (d_w_en) n_w++;
      if (!stall && !dropped) begin
        @(posedge clk); #1;
        clear_ex();
        dropped = 1'b1;
      end
    end
    dm_ready = 1'b0;
    check("held_alu_count", 32'(n_alu), 32'd1);
    check("held_store_count", 32'(n_w), 32'd1);
    check("held_order", {31'd0, order_ok}, 32'd1);
    check("held_d_out", d_out, 32'h0000_0ABC);

    // Reset while a load is waiting on the bus.
    @(negedge clk);
    drive_ex(5'd3, 3'b010, 32'h0000_9000, 32'h0, OP_LD);
    @(posedge clk); #1;
    clear_ex();
    @(negedge clk);
    check("midbus_req_before", {30'd0, dm_req, stall}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("midbus_req_stall", {30'd0, dm_req, stall}, 32'd0);
    check("midbus_bus_out", {dm_be, 27'd0, dm_we}, 32'd0);
    check("midbus_addr", dm_addr, 32'd0);
    check("midbus_d_out", d_out, 32'd0);
    check("midbus_rd_f3", {24'd0, alu_rd, f3_out}, 32'd0);
    check("midbus_enables", {28'd0, alu_reg_w_en, d_r_en, d_w_en, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    guard = 0;
    repeat (3) begin
      @(negedge clk);
      if (dm_req) guard++;
    end
    check("midbus_no_reissue", 32'(guard), 32'd0);
    run_vec("post_reset_alu", mk(5'd4, 3'b111, 32'h0BAD_CAFE, 32'h0, OP_ALU, 0, 32'h0, 1, 0,
                                  EN_ALU, 1'b1, 32'h0BAD_CAFE, 32'h0, 4'b0000, 32'h0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
